// File: rtl/div_sequencer_pkg.sv
// Shared types and constants for the iterative divider.
// Imported by the interface, the step cell and the sequencer top.
package div_sequencer_pkg;

    localparam int RegWidth = 32;

    typedef logic [RegWidth-1:0] regval_t;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ITERATE,
        FIXUP,
        DONE
    } div_state_t;

    localparam regval_t DivZeroQuotient = 32'hFFFF_FFFF;

    // Two's-complement magnitude; 0x8000_0000 maps to itself, which reads as 2^31 unsigned.
    function automatic regval_t abs_val(input regval_t v, input logic en);
        return (en && v[RegWidth-1]) ? -v : v;
    endfunction

endpackage

// File: rtl/div_sequencer_if.sv
// Request/result bundle between execute (master) and the divider (slave).
// Request fields are sampled with start; results hold until the next request overwrites them.
interface div_sequencer_if;
    import div_sequencer_pkg::*;

    logic    start;
    logic    is_signed;
    regval_t numer;
    regval_t denom;
    logic    cancel;
    logic    busy;
    logic    done;
    regval_t quotient;
    regval_t remainder;
    logic    divide_by_zero;

    modport master (
        output start, is_signed, numer, denom, cancel,
        input  busy, done, quotient, remainder, divide_by_zero
    );

    modport slave (
        input  start, is_signed, numer, denom, cancel,
        output busy, done, quotient, remainder, divide_by_zero
    );

endinterface

// File: rtl/div_sequencer_step.sv
// One combinational restoring-division step on unsigned magnitudes.
// Shifts {rem, quo} left by one and subtracts the divisor when it fits.
module div_step
    import div_sequencer_pkg::*;
(
    input  regval_t rem,
    input  regval_t quo,
    input  regval_t divisor,
    output regval_t rem_next,
    output regval_t quo_next
);

    logic [RegWidth:0] w_shifted;
    logic              w_fits;
    regval_t           w_diff;

    assign w_shifted = {rem, quo[RegWidth-1]};
    assign w_fits    = (w_shifted >= {1'b0, divisor});
    // rem < divisor on entry, so whenever the trial fits the difference is below 2^32.
    assign w_diff    = w_shifted[RegWidth-1:0] - divisor;

    assign rem_next = w_fits ? w_diff : w_shifted[RegWidth-1:0];
    assign quo_next = {quo[RegWidth-2:0], w_fits};

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle signed/unsigned 32-bit divider with start/done handshake.
// Magnitudes are divided by a chain of restoring steps, then signs are applied in FIXUP.
module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int Width         = 32,
    parameter int StepsPerCycle = 1
) (
    input  logic           clock,
    input  logic           reset,
    div_sequencer_if.slave bus
);

    localparam int         Iters   = Width / StepsPerCycle;
    localparam logic [4:0] CntLoad = 5'(Iters - 1);

    div_state_t r_state;
    logic [4:0] r_cnt;
    logic       r_busy;
    logic       r_done;

    regval_t    r_numer;
    regval_t    r_denom;
    logic       r_is_signed;
    regval_t    r_div;
    regval_t    r_rem;
    regval_t    r_quo;
    logic       r_q_neg;
    logic       r_r_neg;
    regval_t    r_quotient;
    regval_t    r_remainder;
    logic       r_dbz;

    logic       w_accept;
    logic       w_denom_zero;
    regval_t    w_rem_chain [0:StepsPerCycle];
    regval_t    w_quo_chain [0:StepsPerCycle];

    assign w_accept     = (r_state == IDLE) && bus.start && !bus.cancel;
    assign w_denom_zero = (r_denom == '0);

    assign w_rem_chain[0] = r_rem;
    assign w_quo_chain[0] = r_quo;

    generate
        for (genvar gi = 0; gi < StepsPerCycle; gi++) begin : g_step
            div_step u_step (
                .rem      (w_rem_chain[gi]),
                .quo      (w_quo_chain[gi]),
                .divisor  (r_div),
                .rem_next (w_rem_chain[gi+1]),
                .quo_next (w_quo_chain[gi+1])
            );
        end
    endgenerate

    // Control FSM: cancel overrides every state and drops a simultaneous start.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (bus.cancel) begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (bus.start) begin
                            r_state <= SETUP;
                            r_busy  <= 1'b1;
                        end
                    end
                    SETUP: begin
                        if (w_denom_zero) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ITERATE;
                            r_cnt   <= CntLoad;
                        end
                    end
                    ITERATE: begin
                        if (r_cnt == '0) begin
                            r_state <= FIXUP;
                        end else begin
                            r_cnt <= r_cnt - 5'd1;
                        end
                    end
                    FIXUP: begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
                    DONE: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Datapath: results only change in SETUP (divide by zero) or FIXUP, never on cancel.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_numer     <= '0;
            r_denom     <= '0;
            r_is_signed <= 1'b0;
            r_div       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_q_neg     <= 1'b0;
            r_r_neg     <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else if (!bus.cancel) begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_numer     <= bus.numer;
                        r_denom     <= bus.denom;
                        r_is_signed <= bus.is_signed;
                    end
                end
                SETUP: begin
                    r_dbz <= 1'b0;
                    if (w_denom_zero) begin
                        r_quotient  <= DivZeroQuotient;
                        r_remainder <= r_numer;
                        r_dbz       <= 1'b1;
                    end else begin
                        r_div   <= abs_val(r_denom, r_is_signed);
                        r_quo   <= abs_val(r_numer, r_is_signed);
                        r_rem   <= '0;
                        r_q_neg <= r_is_signed & (r_numer[RegWidth-1] ^ r_denom[RegWidth-1]);
                        r_r_neg <= r_is_signed & r_numer[RegWidth-1];
                    end
                end
                ITERATE: begin
                    r_rem <= w_rem_chain[StepsPerCycle];
                    r_quo <= w_quo_chain[StepsPerCycle];
                end
                FIXUP: begin
                    r_quotient  <= r_q_neg ? -r_quo : r_quo;
                    r_remainder <= r_r_neg ? -r_rem : r_rem;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy           = r_busy;
    assign bus.done           = r_done;
    assign bus.quotient       = r_quotient;
    assign bus.remainder      = r_remainder;
    assign bus.divide_by_zero = r_dbz;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer, run once per instance (StepsPerCycle 1 and 4).
// Both instances share request inputs; start is steered to the instance under test.
module tb_div_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        t_start = 1'b0;
    logic        t_sgn = 1'b0;
    logic        t_cancel = 1'b0;
    logic [31:0] t_numer = '0;
    logic [31:0] t_denom = '0;

    logic        busy, done, dbz;
    logic [31:0] quot, rem;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    div_sequencer_if if_s1 ();
    div_sequencer_if if_s4 ();

    assign if_s1.start     = t_start & ~sel;
    assign if_s1.is_signed = t_sgn;
    assign if_s1.numer     = t_numer;
    assign if_s1.denom     = t_denom;
    assign if_s1.cancel    = t_cancel;
    assign if_s4.start     = t_start & sel;
    assign if_s4.is_signed = t_sgn;
    assign if_s4.numer     = t_numer;
    assign if_s4.denom     = t_denom;
    assign if_s4.cancel    = t_cancel;

    div_sequencer #(.Width(32), .StepsPerCycle(1)) u_dut1 (
        .clock (clk),
        .reset (rst),
        .bus   (if_s1)
    );

    div_sequencer #(.Width(32), .StepsPerCycle(4)) u_dut4 (
        .clock (clk),
        .reset (rst),
        .bus   (if_s4)
    );

    assign busy = sel ? if_s4.busy           : if_s1.busy;
    assign done = sel ? if_s4.done           : if_s1.done;
    assign dbz  = sel ? if_s4.divide_by_zero : if_s1.divide_by_zero;
    assign quot = sel ? if_s4.quotient       : if_s1.quotient;
    assign rem  = sel ? if_s4.remainder      : if_s1.remainder;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s (S=%0d) observed=%h expected=%h", tag, sel ? 4 : 1, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input logic sgn, input logic [31:0] n,
                          input logic [31:0] d, input logic [31:0] eq, input logic [31:0] er,
                          input logic edz, input int elat);
        int lat;
        logic busy_ok;
        lat     = 0;
        busy_ok = 1'b1;
        t_start = 1'b1;
        t_sgn   = sgn;
        t_numer = n;
        t_denom = d;
        tick();
        t_start = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (done === 1'b1) begin
                lat = c;
                break;
            end
            tick();
        end
        $display("op %s S=%0d sgn=%0d %h/%h -> q=%h r=%h dz=%0d latency=%0d",
                 tag, sel ? 4 : 1, sgn, n, d, quot, rem, dbz, lat);
        chk({tag, " latency"}, 32'(lat), 32'(elat));
        chk({tag, " busy held"}, {31'd0, busy_ok}, 32'd1);
        chk({tag, " quotient"}, quot, eq);
        chk({tag, " remainder"}, rem, er);
        chk({tag, " dbz"}, {31'd0, dbz}, {31'd0, edz});
        tick();
        chk({tag, " busy after done"}, {31'd0, busy}, 32'd0);
        chk({tag, " done one cycle"}, {31'd0, done}, 32'd0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int lat_full;
        int p_cyc;
        int c_cyc;
        int r_cyc;
        logic saw_done;

        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            chk("reset busy", {31'd0, busy}, 32'd0);
            chk("reset done", {31'd0, done}, 32'd0);
            chk("reset quotient", quot, 32'd0);
            chk("reset remainder", rem, 32'd0);
            chk("reset dbz", {31'd0, dbz}, 32'd0);
        end
        rst = 1'b0;
        tick();

        for (int s = 0; s < 2; s++) begin
            sel      = s[0];
            lat_full = s ? 11 : 35;
            p_cyc    = s ? 3 : 10;
            c_cyc    = s ? 6 : 20;
            r_cyc    = s ? 5 : 15;
            tick();

            run_op("u100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, lat_full);
            run_op("s-7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, lat_full);
            run_op("s7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, lat_full);
            run_op("smin/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, lat_full);
            run_op("umin/max", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, lat_full);
            run_op("div0", 1'b0, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1, 2);
            run_op("u10/3", 1'b0, 32'd10, 32'd3, 32'd3, 32'd1, 1'b0, lat_full);

            // Cancel mid-operation, with an ignored start pulse beforehand.
            saw_done = 1'b0;
            t_start  = 1'b1;
            t_sgn    = 1'b0;
            t_numer  = 32'd100;
            t_denom  = 32'd7;
            tick();
            for (int c = 1; c <= c_cyc + 3; c++) begin
                t_start  = (c == p_cyc);
                t_cancel = (c == c_cyc);
                if (c == p_cyc) begin
                    t_numer = 32'd9;
                    t_denom = 32'd3;
                end
                if (done === 1'b1) saw_done = 1'b1;
                if (c == c_cyc) chk("cancel busy before", {31'd0, busy}, 32'd1);
                if (c == c_cyc + 1) chk("cancel busy after", {31'd0, busy}, 32'd0);
                tick();
            end
            t_start  = 1'b0;
            t_cancel = 1'b0;
            $display("op cancel S=%0d q=%h r=%h dz=%0d", sel ? 4 : 1, quot, rem, dbz);
            chk("cancel no done", {31'd0, saw_done}, 32'd0);
            chk("cancel holds quotient", quot, 32'd3);
            chk("cancel holds remainder", rem, 32'd1);
            chk("cancel holds dbz", {31'd0, dbz}, 32'd0);

            // Cancel with start in IDLE drops the request.
            t_start  = 1'b1;
            t_cancel = 1'b1;
            t_numer  = 32'd5;
            t_denom  = 32'd1;
            tick();
            t_start  = 1'b0;
            t_cancel = 1'b0;
            $display("op cancel+start S=%0d busy=%0d", sel ? 4 : 1, busy);
            chk("cancel+start busy", {31'd0, busy}, 32'd0);
            tick();
            chk("cancel+start quotient", quot, 32'd3);

            // Asynchronous reset mid-operation.
            t_start = 1'b1;
            t_numer = 32'd100;
            t_denom = 32'd7;
            tick();
            t_start = 1'b0;
            for (int c = 1; c < r_cyc; c++) tick();
            chk("pre-reset busy", {31'd0, busy}, 32'd1);
            rst = 1'b1;
            #1;
            $display("op reset S=%0d busy=%0d q=%h r=%h", sel ? 4 : 1, busy, quot, rem);
            chk("reset busy mid-op", {31'd0, busy}, 32'd0);
            chk("reset done mid-op", {31'd0, done}, 32'd0);
            chk("reset quotient mid-op", quot, 32'd0);
            chk("reset remainder mid-op", rem, 32'd0);
            chk("reset dbz mid-op", {31'd0, dbz}, 32'd0);
            #1;
            rst = 1'b0;
            tick();
            run_op("u50/5", 1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 1'b0, lat_full);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
